// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope: state encodings and widths.
package adsr_pkg;

    localparam int STATE_W = 3;

    // Encodings are visible on state_out, so the values are fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_gain_mult.sv
// Output stage: scales a signed sample by an unsigned gain, optionally
// converts to offset binary, and registers the result with a delayed strobe.
module adsr_gain_mult
    import adsr_pkg::*;
#(
    parameter int SAMPLE_W   = 12,
    parameter int GAIN_W     = 12,
    parameter int OFFSET_OUT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [SAMPLE_W-1:0] i_wave,
    input  logic [GAIN_W-1:0]   i_gain,
    output logic [SAMPLE_W-1:0] o_wave,
    output logic                o_en
);

    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

    logic signed [PROD_W-1:0] w_a;
    logic signed [PROD_W-1:0] w_b;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shift;
    logic        [SAMPLE_W-1:0] w_offset;
    logic        [SAMPLE_W-1:0] w_wave;
    logic                     w_unused_hi;

    logic [SAMPLE_W-1:0] r_wave;
    logic                r_en;

    // Sample is sign-extended; gain is zero-extended so it multiplies as a
    // non-negative value in a signed product.
    assign w_a      = {{(GAIN_W + 1){i_wave[SAMPLE_W-1]}}, i_wave};
    assign w_b      = {{(SAMPLE_W + 1){1'b0}}, i_gain};
    assign w_prod   = w_a * w_b;
    assign w_shift  = w_prod >>> GAIN_W;
    assign w_offset = (OFFSET_OUT != 0) ? {1'b1, {(SAMPLE_W - 1){1'b0}}} : '0;
    assign w_wave   = w_shift[SAMPLE_W-1:0] + w_offset;

    // Upper bits of the shifted product are dropped by the truncation.
    assign w_unused_hi = ^w_shift[PROD_W-1:SAMPLE_W];

    // Capture the scaled sample on each strobe and hold it in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wave <= '0;
            r_en   <= 1'b0;
        end else begin
            r_en <= i_en;
            if (i_en) begin
                r_wave <= w_wave;
            end
        end
    end

    assign o_wave = r_wave;
    assign o_en   = r_en;

endmodule

// File: rtl/adsr_env.sv
// Four-stage ADSR amplitude envelope with linear rate-based ramps.
// Handshake: en_in is a one-cycle sample strobe with no back-pressure; every
// state/gain update happens only on en_in cycles, and en_out marks the cycle
// in which wave_out carries the sample of the previous strobe.
module adsr_env
    import adsr_pkg::*;
#(
    parameter int SAMPLE_W    = 12,
    parameter int GAIN_W      = 12,
    parameter int RETRIG_ZERO = 0,
    parameter int OFFSET_OUT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_in,
    input  logic                gate,
    input  logic [GAIN_W-1:0]   attack_rate,
    input  logic [GAIN_W-1:0]   decay_rate,
    input  logic [GAIN_W-1:0]   sustain_level,
    input  logic [GAIN_W-1:0]   release_rate,
    input  logic [SAMPLE_W-1:0] wave_in,
    output logic [SAMPLE_W-1:0] wave_out,
    output logic                en_out,
    output logic [GAIN_W-1:0]   gain_out,
    output logic [STATE_W-1:0]  state_out,
    output logic                active
);

    localparam logic [GAIN_W-1:0] GMAX = {GAIN_W{1'b1}};

    adsr_state_t       r_state;
    adsr_state_t       w_state_nxt;
    logic [GAIN_W-1:0] r_gain;
    logic [GAIN_W-1:0] w_gain_nxt;

    logic [GAIN_W-1:0] w_att_base;
    logic [GAIN_W:0]   w_att_sum;
    logic              w_att_full;
    logic [GAIN_W-1:0] w_att_gain;
    logic              w_dec_hold;
    logic [GAIN_W-1:0] w_dec_gain;
    logic              w_rel_hold;
    logic [GAIN_W-1:0] w_rel_gain;

    // Attack ramp: retrigger from RELEASE may restart from zero; the extra
    // sum bit catches overflow so the ramp clamps at full scale.
    assign w_att_base = (r_state == ST_RELEASE && RETRIG_ZERO != 0) ? '0 : r_gain;
    assign w_att_sum  = {1'b0, w_att_base} + {1'b0, attack_rate};
    assign w_att_full = (attack_rate == '0) || (w_att_sum >= {1'b0, GMAX});
    assign w_att_gain = w_att_full ? GMAX : w_att_sum[GAIN_W-1:0];

    // Decay ramp: keep stepping only while a full step stays above sustain;
    // otherwise land on sustain (this also lifts a gain below sustain).
    assign w_dec_hold = (decay_rate != '0) && (r_gain > sustain_level) &&
                        ((r_gain - sustain_level) > decay_rate);
    assign w_dec_gain = w_dec_hold ? (r_gain - decay_rate) : sustain_level;

    // Release ramp: saturates at zero instead of wrapping.
    assign w_rel_hold = (release_rate != '0) && (r_gain > release_rate);
    assign w_rel_gain = w_rel_hold ? (r_gain - release_rate) : '0;

    // Next-state and next-gain selection, evaluated only on strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        if (en_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (gate) begin
                        w_gain_nxt  = w_att_gain;
                        w_state_nxt = w_att_full ? ST_DECAY : ST_ATTACK;
                    end else begin
                        w_gain_nxt  = '0;
                    end
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        w_gain_nxt  = w_rel_gain;
                        w_state_nxt = w_rel_hold ? ST_RELEASE : ST_IDLE;
                    end else begin
                        w_gain_nxt  = w_att_gain;
                        w_state_nxt = w_att_full ? ST_DECAY : ST_ATTACK;
                    end
                end
                ST_DECAY: begin
                    if (!gate) begin
                        w_gain_nxt  = w_rel_gain;
                        w_state_nxt = w_rel_hold ? ST_RELEASE : ST_IDLE;
                    end else begin
                        w_gain_nxt  = w_dec_gain;
                        w_state_nxt = w_dec_hold ? ST_DECAY : ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) begin
                        w_gain_nxt  = w_rel_gain;
                        w_state_nxt = w_rel_hold ? ST_RELEASE : ST_IDLE;
                    end else begin
                        w_gain_nxt  = sustain_level;
                    end
                end
                ST_RELEASE: begin
                    if (gate) begin
                        w_gain_nxt  = w_att_gain;
                        w_state_nxt = w_att_full ? ST_DECAY : ST_ATTACK;
                    end else begin
                        w_gain_nxt  = w_rel_gain;
                        w_state_nxt = w_rel_hold ? ST_RELEASE : ST_IDLE;
                    end
                end
                default: begin
                    w_gain_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and gain registers; reset wins over a simultaneous strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gain  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
        end
    end

    // The multiplier sees the gain before this strobe's update.
    adsr_gain_mult #(
        .SAMPLE_W   (SAMPLE_W),
        .GAIN_W     (GAIN_W),
        .OFFSET_OUT (OFFSET_OUT)
    ) u_mult (
        .clk    (clk),
        .rst    (rst),
        .i_en   (en_in),
        .i_wave (wave_in),
        .i_gain (r_gain),
        .o_wave (wave_out),
        .o_en   (en_out)
    );

    assign gain_out  = r_gain;
    assign state_out = r_state;
    assign active    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adsr_env.sv
// Bench for adsr_env: two instances (legato and zero-retrigger) share one
// stimulus stream and are compared against an arithmetic envelope model.
module tb_adsr_env;

  localparam int GMAX = 4095;
  localparam int P_IDLE = 0, P_ATTACK = 1, P_DECAY = 2, P_SUSTAIN = 3, P_RELEASE = 4;

  logic clk = 1'b0;
  logic rst;
  logic en_in;
  logic gate;
  logic [11:0] attack_rate, decay_rate, sustain_level, release_rate;
  logic [11:0] wave_in;

  logic [1:0][11:0] wave_out;
  logic [1:0][11:0] gain_out;
  logic [1:0][2:0]  state_out;
  logic [1:0]       en_out;
  logic [1:0]       active;

  int n_checks = 0;
  int n_fail = 0;

  // model: per instance phase, gain, expected held output sample
  int m_st[2];
  int m_g[2];
  int m_w[2];

  always #5 clk = ~clk;

  adsr_env #(.SAMPLE_W(12), .GAIN_W(12), .RETRIG_ZERO(0), .OFFSET_OUT(1)) dut0 (
    .clk(clk), .rst(rst), .en_in(en_in), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .wave_in(wave_in), .wave_out(wave_out[0]), .en_out(en_out[0]),
    .gain_out(gain_out[0]), .state_out(state_out[0]), .active(active[0])
  );

  adsr_env #(.SAMPLE_W(12), .GAIN_W(12), .RETRIG_ZERO(1), .OFFSET_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .en_in(en_in), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .wave_in(wave_in), .wave_out(wave_out[1]), .en_out(en_out[1]),
    .gain_out(gain_out[1]), .state_out(state_out[1]), .active(active[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = P_IDLE;
      m_g[k] = 0;
      m_w[k] = 0;
    end
  endtask

  // Envelope rules in plain integer arithmetic; k==1 restarts attack at 0.
  task automatic model_step(input bit g, input int win);
    int ar, dr, sl, rr;
    ar = int'(attack_rate);
    dr = int'(decay_rate);
    sl = int'(sustain_level);
    rr = int'(release_rate);
    for (int k = 0; k < 2; k++) begin
      int p, gg, st;
      p = win * m_g[k];
      m_w[k] = ((p >>> 12) + 2048) & 4095;
      gg = m_g[k];
      st = m_st[k];
      if (!g && st == P_IDLE) begin
        gg = 0;
      end else if (!g) begin
        gg = (rr == 0 || gg - rr < 0) ? 0 : gg - rr;
        st = (gg == 0) ? P_IDLE : P_RELEASE;
      end else if (st == P_DECAY) begin
        gg = (dr == 0 || gg - dr < sl) ? sl : gg - dr;
        st = (gg == sl) ? P_SUSTAIN : P_DECAY;
      end else if (st == P_SUSTAIN) begin
        gg = sl;
      end else begin
        if (st == P_RELEASE && k == 1) gg = 0;
        gg = (ar == 0 || gg + ar > GMAX) ? GMAX : gg + ar;
        st = (gg == GMAX) ? P_DECAY : P_ATTACK;
      end
      m_g[k] = gg;
      m_st[k] = st;
    end
  endtask

  task automatic check_all(input string tag, input int en_exp);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_i%0d_gain", tag, k), int'(gain_out[k]), m_g[k]);
      check($sformatf("%s_i%0d_state", tag, k), int'(state_out[k]), m_st[k]);
      check($sformatf("%s_i%0d_active", tag, k), int'(active[k]), (m_st[k] != P_IDLE) ? 1 : 0);
      check($sformatf("%s_i%0d_wave", tag, k), int'(wave_out[k]), m_w[k]);
      check($sformatf("%s_i%0d_en_out", tag, k), int'(en_out[k]), en_exp);
    end
  endtask

  // One strobe, then one quiet cycle; called at a falling edge.
  task automatic strobe(input string tag, input bit g, input int win);
    gate = g;
    wave_in = win[11:0];
    en_in = 1'b1;
    model_step(g, win);
    @(negedge clk);
    en_in = 1'b0;
    check_all(tag, 1);
    @(negedge clk);
    check_all({tag, "_hold"}, 0);
  endtask

  task automatic set_rates(input int ar, input int dr, input int sl, input int rr);
    attack_rate = ar[11:0];
    decay_rate = dr[11:0];
    sustain_level = sl[11:0];
    release_rate = rr[11:0];
  endtask

  initial begin
    rst = 1'b1;
    en_in = 1'b0;
    gate = 1'b0;
    wave_in = '0;
    set_rates(1024, 512, 3000, 1000);
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset", 0);
    rst = 1'b0;
    @(negedge clk);

    // attack/decay/sustain profile
    for (int i = 0; i < 8; i++) strobe("ads", 1'b1, 0);
    check("ads_final_gain", int'(gain_out[0]), 3000);
    check("ads_final_state", int'(state_out[0]), 3);

    // release to idle
    for (int i = 0; i < 3; i++) strobe("rel", 1'b0, 0);
    check("rel_final_gain", int'(gain_out[0]), 0);
    check("rel_final_active", int'(active[0]), 0);

    // output arithmetic
    strobe("math_a", 1'b1, 0);
    strobe("math_b", 1'b1, 0);
    strobe("math_c", 1'b1, 1000);
    check("math_2548", int'(wave_out[0]), 2548);
    strobe("math_d", 1'b1, 0);
    strobe("math_e", 1'b1, -2048);
    check("math_neg_full", int'(wave_out[0]), 0);
    set_rates(1024, 512, 3000, 0);
    strobe("math_f", 1'b0, 0);
    strobe("math_g", 1'b0, 1234);
    check("math_zero_gain", int'(wave_out[0]), 2048);

    // retrigger from release at 1500
    set_rates(1024, 512, 2500, 1000);
    for (int i = 0; i < 9; i++) strobe("rt_up", 1'b1, 0);
    strobe("rt_rel", 1'b0, 0);
    check("rt_rel_gain", int'(gain_out[0]), 1500);
    set_rates(1000, 512, 2500, 1000);
    strobe("rt_att", 1'b1, 0);
    check("retrig_legato", int'(gain_out[0]), 2500);
    check("retrig_zero", int'(gain_out[1]), 1000);
    set_rates(1000, 512, 2500, 0);
    strobe("rt_off", 1'b0, 0);

    // zero rates
    set_rates(0, 0, 2000, 0);
    strobe("zr_on", 1'b1, 500);
    check("zr_att_gain", int'(gain_out[0]), 4095);
    strobe("zr_dec", 1'b1, 500);
    check("zr_sus_gain", int'(gain_out[0]), 2000);
    strobe("zr_off", 1'b0, 500);
    check("zr_rel_gain", int'(gain_out[0]), 0);

    // reset mid-attack coinciding with a strobe
    set_rates(1024, 512, 3000, 1000);
    strobe("rs_att", 1'b1, 700);
    gate = 1'b1;
    wave_in = 12'd700;
    en_in = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en_in = 1'b0;
    model_reset();
    check_all("rs_mid", 0);
    strobe("rs_resume", 1'b1, 700);
    check("rs_resume_gain", int'(gain_out[0]), 1024);

    // randomized strobes with live rate changes and gaps
    begin
      bit g;
      g = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 5) == 0) g = ~g;
        if ($urandom_range(0, 3) == 0) begin
          set_rates(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1500)),
                    ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1500)),
                    int'($urandom_range(0, 4095)),
                    ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1500)));
        end
        strobe("rnd", g, int'($urandom_range(0, 4095)) - 2048);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check_all("rnd_gap", 0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
Parametrised successor to the two-stage rise/fall envelope: a full four-stage ADSR (attack, decay, sustain, release) amplitude shaper. It sits between a voice oscillator (wave_in, sample strobe en_in) and the audio mixer/DAC path. It uses rate-based linear ramps, so no hardware divider is needed. Sustain level is programmable, retrigger mode is selectable, offset-binary output is optional, and gain/state are exposed for CSR readback.

Parameters:
SAMPLE_W, 12, width of wave_in/wave_out samples
GAIN_W, 12, width of envelope gain, rates and sustain level; GMAX = 2^GAIN_W-1
RETRIG_ZERO, 0, 1: entering ATTACK forces gain to 0; 0: attack continues from current gain (legato)
OFFSET_OUT, 1, 1: wave_out is offset binary (+2^(SAMPLE_W-1)); 0: two's complement

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en_in  in  1  sample strobe, one cycle per audio sample
gate  in  1  key held; sampled only on en_in cycles
attack_rate  in  GAIN_W  gain increment per strobe in ATTACK; 0 = instantaneous
decay_rate  in  GAIN_W  gain decrement per strobe in DECAY; 0 = instantaneous
sustain_level  in  GAIN_W  SUSTAIN target gain
release_rate  in  GAIN_W  gain decrement per strobe in RELEASE; 0 = instantaneous
wave_in  in  SAMPLE_W  signed two's complement input sample
wave_out  out  SAMPLE_W  shaped sample
en_out  out  1  en_in delayed one cycle; marks wave_out valid
gain_out  out  GAIN_W  current envelope gain
state_out  out  3  encoded state (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4)
active  out  1  state != IDLE

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high. All state advances only on cycles with en_in=1; other cycles hold.
- Reset values: state IDLE, gain 0, wave_out 0, en_out 0, active 0. Reset dominates en_in in the same cycle. Reset mid-ramp returns to IDLE/gain 0 on the next edge and kills any pending en_out.
- Output path: on an en_in cycle, product = wave_in * {0,gain} (signed, SAMPLE_W+GAIN_W+1 bits) uses the pre-update gain. wave_out = (product >>> GAIN_W) truncated to SAMPLE_W, plus 2^(SAMPLE_W-1) mod 2^SAMPLE_W when OFFSET_OUT=1. wave_out is registered and en_out=1 the following cycle. Latency is 1 cycle, and wave_out holds between strobes.
- Transitions and gain updates, evaluated on en_in:
 - IDLE: gate=1 -> ATTACK, and the gain update for ATTACK applies in the same strobe. Otherwise gain stays 0.
 - ATTACK: gain = min(gain+attack_rate, GMAX), computed with a GAIN_W+1-bit sum. When the new gain is GMAX -> DECAY. If attack_rate=0, gain = GMAX immediately.
 - DECAY: gain = max(gain-decay_rate, sustain_level). When it reaches sustain_level -> SUSTAIN. If decay_rate=0, jump to sustain_level.
 - SUSTAIN: gain = sustain_level, read live so CSR changes track each strobe.
 - RELEASE: gain = max(gain-release_rate, 0) with no underflow. When it reaches 0 -> IDLE. If release_rate=0, gain = 0 immediately.
- gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE, starting from current gain; the release decrement applies in that strobe.
- gate=1 in RELEASE -> ATTACK. Gain starts from its current value, or 0 if RETRIG_ZERO=1.
- If sustain_level is above the gain on entering DECAY, gain rises to sustain_level in one strobe.
- Rates are read live every strobe; no latching.

Decomposition:
- Shared package adsr_pkg: state encodings and the state_out width constant.
- Sub-module adsr_gain_mult: registered signed multiply, arithmetic shift, optional offset, en_out delay.
- The FSM and gain datapath stay in adsr_env.

Test Plan:
- Defaults: attack_rate=1024, decay_rate=512, sustain_level=3000, gate held from strobe 1 -> gain 1024, 2048, 3072, 4095, then DECAY 3583, 3071, 3000, then SUSTAIN. state_out sequence is 1,1,1,1→2,2,2,2→3.
- From SUSTAIN (gain 3000), drop gate with release_rate=1000 -> gain 2000, 1000, 0, then state IDLE and active=0 after the third strobe.
- Output math with gain 2048, wave_in=1000 -> wave_out=2548. With gain 4095, wave_in=-2048 -> wave_out=0. With gain 0 -> wave_out=2048. en_out asserts exactly one cycle after en_in.
- Retrigger in RELEASE at gain 1500 with attack_rate=1000 -> RETRIG_ZERO=0 gives gain 2500; RETRIG_ZERO=1 gives gain 1000.
- Zero rates (attack/decay/release_rate=0, sustain_level=2000) -> gate on: 4095 then 2000; gate off: 0 in a single strobe.
- Assert rst for one cycle mid-ATTACK, simultaneous with en_in -> next cycle state 0, gain 0, wave_out 0, en_out 0. gate held -> ATTACK resumes on the next strobe.
